// File: rtl/ila_verdict.sv
// Self-test verdict sequencer: debounces the register-file and data-memory checker
// results after halt and latches a sticky pass/fail verdict with cause and run length.
module ila_verdict #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             rm_ok,
  input  logic             dm_ok,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_cause,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_PASS   = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
  localparam int WIN_W = $clog2(2 * STABLE_CYCLES) + 1;

  localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WINDOW_LAST  = WIN_W'(2 * STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_r, state_s;
  logic [STB_W-1:0] stable_r, stable_s;
  logic [WIN_W-1:0] window_r, window_s;
  logic [CNT_W-1:0] cycles_r, cycles_s;
  logic [1:0]       cause_r, cause_s;
  logic             busy_r, done_r, pass_r, fail_r;
  logic             both_ok_s, pass_cond_s, active_s;

  assign both_ok_s   = rm_ok & dm_ok;
  // True on the Nth consecutive cycle with both checkers matching.
  assign pass_cond_s = both_ok_s && (stable_r == STABLE_LAST);
  assign active_s    = (state_r == S_RUN) || (state_r == S_SETTLE);

  // Next-state and counter update; start overrides every other transition.
  always_comb begin
    state_s  = state_r;
    stable_s = stable_r;
    window_s = window_r;
    cycles_s = cycles_r;
    cause_s  = cause_r;
    if (start) begin
      state_s  = S_RUN;
      stable_s = '0;
      window_s = '0;
      cycles_s = '0;
      cause_s  = 2'd0;
    end else begin
      if (active_s) begin
        stable_s = both_ok_s ? (stable_r + STB_W'(1)) : '0;
        cycles_s = (&cycles_r) ? cycles_r : (cycles_r + CNT_W'(1));
      end else begin
        stable_s = stable_r;
      end
      case (state_r)
        S_IDLE: state_s = S_IDLE;
        S_RUN: begin
          if (pass_cond_s) begin
            state_s = S_PASS;
          end else if (cycles_r == TIMEOUT_LAST) begin
            state_s = S_FAIL;
            cause_s = 2'd1;
          end else if (halt) begin
            state_s  = S_SETTLE;
            window_s = '0;
          end else begin
            state_s = S_RUN;
          end
        end
        S_SETTLE: begin
          window_s = window_r + WIN_W'(1);
          if (pass_cond_s) begin
            state_s = S_PASS;
          end else if (window_r == WINDOW_LAST) begin
            state_s = S_FAIL;
            cause_s = 2'd2;
          end else begin
            state_s = S_SETTLE;
          end
        end
        S_PASS: begin
          if (!both_ok_s) begin
            state_s = S_FAIL;
            cause_s = 2'd3;
          end else begin
            state_s = S_PASS;
          end
        end
        S_FAIL:  state_s = S_FAIL;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State, counters and status flags; flags are decoded from the next state so they are flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      stable_r <= '0;
      window_r <= '0;
      cycles_r <= '0;
      cause_r  <= 2'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      stable_r <= stable_s;
      window_r <= window_s;
      cycles_r <= cycles_s;
      cause_r  <= cause_s;
      busy_r   <= (state_s == S_RUN) || (state_s == S_SETTLE);
      done_r   <= (state_s == S_PASS) || (state_s == S_FAIL);
      pass_r   <= (state_s == S_PASS);
      fail_r   <= (state_s == S_FAIL);
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign fail       = fail_r;
  assign fail_cause = cause_r;
  assign cycles     = cycles_r;

endmodule

// File: tb/tb_ila_verdict.sv
// Scenario bench for ila_verdict with STABLE_CYCLES=4, TIMEOUT_CYCLES=32, plus a
// randomized run compared against a streak/run-length reference model.
module tb_ila_verdict;

  localparam int S = 4;
  localparam int T = 32;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         halt = 1'b0;
  logic         rm_ok = 1'b0;
  logic         dm_ok = 1'b0;
  logic         busy, done, pass, fail;
  logic [1:0]   fail_cause;
  logic [W-1:0] cycles;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 run, 2 settle, 3 pass, 4 fail.
  int m_phase = 0;
  int m_streak = 0;
  int m_cyc = 0;
  int m_win = 0;
  int m_cause = 0;

  ila_verdict #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .rm_ok(rm_ok), .dm_ok(dm_ok),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_cause(fail_cause), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input bit st, input bit h, input bit ok);
    int streak_now;
    bool_blk: begin
      if (st) begin
        m_phase = 1; m_streak = 0; m_cyc = 0; m_win = 0; m_cause = 0;
      end else if (m_phase == 1 || m_phase == 2) begin
        streak_now = ok ? m_streak + 1 : 0;
        m_cyc = (m_cyc + 1 > 65535) ? 65535 : m_cyc + 1;
        if (m_phase == 1) begin
          if (streak_now >= S) m_phase = 3;
          else if (m_cyc == T) begin m_phase = 4; m_cause = 1; end
          else if (h) begin m_phase = 2; m_win = 0; end
        end else begin
          m_win = m_win + 1;
          if (streak_now >= S) m_phase = 3;
          else if (m_win == 2 * S) begin m_phase = 4; m_cause = 2; end
        end
        m_streak = streak_now;
      end else if (m_phase == 3 && !ok) begin
        m_phase = 4; m_cause = 3;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, pass, fail} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, fail});
    end
    checks++;
    if (fail_cause !== 2'd0 || cycles !== 16'd0) begin
      errors++; $display("FAIL reset_counts: got cause=%0d cycles=%0d expected 0/0", fail_cause, cycles);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_pass();
    rm_ok = 1'b1; dm_ok = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || cycles !== 16'd0) begin
      errors++; $display("FAIL pass_first_run: got busy=%b cycles=%0d expected 1/0", busy, cycles);
    end
    for (int i = 1; i <= S; i++) begin
      tick();
      if (i == S - 1) begin
        checks++;
        if (pass !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL pass_early: got pass=%b busy=%b expected 0/1", pass, busy);
        end
      end
    end
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0 || done !== 1'b1 || cycles !== 16'd4 || fail_cause !== 2'd0) begin
      errors++; $display("FAIL pass_edge: got pass=%b busy=%b done=%b cycles=%0d cause=%0d expected 1/0/1/4/0",
                         pass, busy, done, cycles, fail_cause);
    end
  endtask

  task automatic test_corrupt();
    dm_ok = 1'b0;
    tick();
    dm_ok = 1'b1;
    checks++;
    if (fail !== 1'b1 || pass !== 1'b0 || fail_cause !== 2'd3 || cycles !== 16'd4) begin
      errors++; $display("FAIL corrupt: got fail=%b pass=%b cause=%0d cycles=%0d expected 1/0/3/4",
                         fail, pass, fail_cause, cycles);
    end
    tick();
    checks++;
    if (fail !== 1'b1 || fail_cause !== 2'd3) begin
      errors++; $display("FAIL fail_sticky: got fail=%b cause=%0d expected 1/3", fail, fail_cause);
    end
    pulse_start();
    checks++;
    if (busy !== 1'b1 || fail !== 1'b0 || cycles !== 16'd0 || fail_cause !== 2'd0) begin
      errors++; $display("FAIL restart: got busy=%b fail=%b cycles=%0d cause=%0d expected 1/0/0/0",
                         busy, fail, cycles, fail_cause);
    end
  endtask

  task automatic test_timeout();
    int n;
    rm_ok = 1'b1; dm_ok = 1'b0;
    pulse_start();
    n = 0;
    for (int i = 1; i <= T + 8; i++) begin
      tick();
      n = i;
      if (fail === 1'b1) break;
    end
    checks++;
    if (fail !== 1'b1 || n != T || cycles !== 16'(T) || fail_cause !== 2'd1) begin
      errors++; $display("FAIL timeout: got fail=%b edges=%0d cycles=%0d cause=%0d expected 1/%0d/%0d/1",
                         fail, n, cycles, fail_cause, T, T);
    end
  endtask

  task automatic test_pattern();
    bit pat [8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rm_ok = 1'b1; dm_ok = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      dm_ok = pat[i];
      tick();
      if (i == 6) begin
        checks++;
        if (pass !== 1'b0) begin
          errors++; $display("FAIL pattern_early: got pass=%b expected 0", pass);
        end
      end
    end
    dm_ok = 1'b1;
    checks++;
    if (pass !== 1'b1 || cycles !== 16'd8) begin
      errors++; $display("FAIL pattern_pass: got pass=%b cycles=%0d expected 1/8", pass, cycles);
    end
  endtask

  task automatic test_settle();
    rm_ok = 1'b1; dm_ok = 1'b0;
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      halt = (i == 5);
      tick();
    end
    halt = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || cycles !== 16'd5) begin
      errors++; $display("FAIL settle_entry: got busy=%b done=%b cycles=%0d expected 1/0/5", busy, done, cycles);
    end
    for (int j = 1; j <= 2 * S; j++) begin
      halt = (j == 3);
      tick();
      if (j == 2 * S - 1) begin
        checks++;
        if (fail !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL settle_early: got fail=%b busy=%b expected 0/1", fail, busy);
        end
      end
    end
    halt = 1'b0;
    checks++;
    if (fail !== 1'b1 || cycles !== 16'd13 || fail_cause !== 2'd2) begin
      errors++; $display("FAIL settle_expire: got fail=%b cycles=%0d cause=%0d expected 1/13/2",
                         fail, cycles, fail_cause);
    end
  endtask

  task automatic test_back_to_back();
    rm_ok = 1'b1; dm_ok = 1'b0;
    pulse_start();
    tick();
    tick();
    dm_ok = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || cycles !== 16'd0) begin
      errors++; $display("FAIL restart_run: got busy=%b cycles=%0d expected 1/0", busy, cycles);
    end
    // start wins over a simultaneous pass condition
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (pass !== 1'b0 || busy !== 1'b1 || cycles !== 16'd0) begin
      errors++; $display("FAIL start_priority: got pass=%b busy=%b cycles=%0d expected 0/1/0", pass, busy, cycles);
    end
  endtask

  task automatic test_async_reset();
    rm_ok = 1'b1; dm_ok = 1'b0;
    pulse_start();
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, fail} !== 4'b0000 || fail_cause !== 2'd0 || cycles !== 16'd0) begin
      errors++; $display("FAIL async_reset: got flags=%b cause=%0d cycles=%0d expected 0000/0/0",
                         {busy, done, pass, fail}, fail_cause, cycles);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cycles !== 16'd0) begin
      errors++; $display("FAIL start_in_reset: got busy=%b done=%b cycles=%0d expected 0/0/0", busy, done, cycles);
    end
  endtask

  task automatic test_random();
    int thr;
    int exp_busy, exp_done, exp_pass, exp_fail;
    rst = 1'b1; #1; rst = 1'b0;
    m_phase = 0; m_streak = 0; m_cyc = 0; m_win = 0; m_cause = 0;
    thr = 8;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) thr = int'($urandom_range(4, 8));
      start = (i == 0) || ($urandom_range(0, 59) == 0);
      halt  = ($urandom_range(0, 9) == 0);
      rm_ok = (int'($urandom_range(0, 7)) < thr);
      dm_ok = (int'($urandom_range(0, 7)) < thr);
      model_edge(start, halt, rm_ok & dm_ok);
      tick();
      exp_busy = (m_phase == 1 || m_phase == 2) ? 1 : 0;
      exp_done = (m_phase == 3 || m_phase == 4) ? 1 : 0;
      exp_pass = (m_phase == 3) ? 1 : 0;
      exp_fail = (m_phase == 4) ? 1 : 0;
      checks++;
      if (busy !== 1'(exp_busy) || done !== 1'(exp_done) || pass !== 1'(exp_pass) || fail !== 1'(exp_fail)
          || fail_cause !== 2'(m_cause) || cycles !== 16'(m_cyc)) begin
        errors++;
        $display("FAIL random[%0d]: got b/d/p/f=%b%b%b%b cause=%0d cycles=%0d expected %0d%0d%0d%0d cause=%0d cycles=%0d",
                 i, busy, done, pass, fail, fail_cause, cycles,
                 exp_busy, exp_done, exp_pass, exp_fail, m_cause, m_cyc);
      end
    end
    start = 1'b0; halt = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_pass();
    test_corrupt();
    test_timeout();
    test_pattern();
    test_settle();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
